// File: rtl/data_mem_block_master_if.sv
// rtl/data_mem_block_master_if.sv - memory port and core-side streams of the block mover
interface data_mem_block_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata, rd_data, rd_valid, wr_ready,
        input  mem_rdata, rd_ready, wr_data, wr_valid
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata, rd_data, rd_valid, wr_ready,
        output mem_rdata, rd_ready, wr_data, wr_valid
    );
endinterface

// File: rtl/data_mem_block_master.sv
// rtl/data_mem_block_master.sv - moves a block of consecutive words between Data_memory and a core stream
module data_mem_block_master #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       dir,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic [15:0]                length,
    output logic                       busy,
    output logic                       done,
    data_mem_block_master_if.master    bus
);
    localparam int LW = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, RD_HOLD, WR_ACC, WR_ISSUE, DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [15:0]       remaining, rem_nxt;
    logic [LW-1:0]     lat_cnt, lat_nxt;
    logic              rd_capture, wr_capture;

    logic              mem_read_q, mem_write_q, rd_valid_q, wr_ready_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, rd_data_q;

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.wr_ready  = wr_ready_q;

    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr;
        rem_nxt    = remaining;
        lat_nxt    = lat_cnt;
        rd_capture = 1'b0;
        wr_capture = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    addr_nxt = base_addr;
                    rem_nxt  = length;
                    if (length == 16'd0) state_nxt = DONE;
                    else if (dir)        state_nxt = WR_ACC;
                    else                 state_nxt = RD_REQ;
                end
            end
            RD_REQ: begin
                lat_nxt   = LW'(1);
                state_nxt = RD_WAIT;
            end
            // lat_cnt counts the cycles since the read strobe; data is sampled on the last one
            RD_WAIT: begin
                if (lat_cnt == LW'(RD_LAT)) begin
                    rd_capture = 1'b1;
                    state_nxt  = RD_HOLD;
                end else begin
                    lat_nxt = lat_cnt + LW'(1);
                end
            end
            RD_HOLD: begin
                if (rd_valid_q && bus.rd_ready) begin
                    rem_nxt   = remaining - 16'd1;
                    addr_nxt  = addr + ADDR_W'(1);
                    state_nxt = (rem_nxt == 16'd0) ? DONE : RD_REQ;
                end
            end
            WR_ACC: begin
                if (wr_ready_q && bus.wr_valid) begin
                    wr_capture = 1'b1;
                    state_nxt  = WR_ISSUE;
                end
            end
            WR_ISSUE: begin
                rem_nxt   = remaining - 16'd1;
                addr_nxt  = addr + ADDR_W'(1);
                state_nxt = (rem_nxt == 16'd0) ? DONE : WR_ACC;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each is a clean Moore signal of its state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr        <= '0;
            remaining   <= '0;
            lat_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            wr_ready_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
        end else begin
            state       <= state_nxt;
            addr        <= addr_nxt;
            remaining   <= rem_nxt;
            lat_cnt     <= lat_nxt;
            busy        <= (state_nxt != IDLE);
            done        <= (state_nxt == DONE);
            mem_read_q  <= (state_nxt == RD_REQ);
            mem_write_q <= (state_nxt == WR_ISSUE);
            rd_valid_q  <= (state_nxt == RD_HOLD);
            wr_ready_q  <= (state_nxt == WR_ACC);
            if (state_nxt == RD_REQ || state_nxt == WR_ISSUE)
                mem_addr_q <= addr_nxt;
            if (rd_capture)
                rd_data_q <= bus.mem_rdata;
            if (wr_capture)
                mem_wdata_q <= bus.wr_data;
        end
    end
endmodule

// File: tb/tb_data_mem_block_master.sv
// tb/tb_data_mem_block_master.sv - scoreboard bench for the block mover against a 1-cycle-latency memory model
module tb_data_mem_block_master;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        dir;
    logic [15:0] base_addr;
    logic [15:0] length;
    logic        busy;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int done_cnt    = 0;
    int done_cyc    = 0;
    int last_hs_cyc = 0;

    logic [15:0] mem [0:65535];
    logic [15:0] exp_raddr [$];
    logic [15:0] exp_rd [$];
    logic [31:0] exp_wr [$];

    data_mem_block_master_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    data_mem_block_master #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dir       (dir),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_read)  bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        check("mem_excl", {31'b0, bus.mem_read & bus.mem_write}, 32'd0);
        if (bus.mem_read) begin
            check("read_expected", {31'b0, exp_raddr.size() != 0}, 32'd1);
            if (exp_raddr.size() != 0) check("mem_read_addr", bus.mem_addr, exp_raddr.pop_front());
        end
        if (bus.mem_write) begin
            check("write_expected", {31'b0, exp_wr.size() != 0}, 32'd1);
            if (exp_wr.size() != 0) check("mem_write_addr_data", {bus.mem_addr, bus.mem_wdata}, exp_wr.pop_front());
        end
        if (bus.rd_valid && bus.rd_ready) begin
            check("rd_expected", {31'b0, exp_rd.size() != 0}, 32'd1);
            if (exp_rd.size() != 0) check("rd_data", bus.rd_data, exp_rd.pop_front());
            last_hs_cyc = cyc;
        end else if (bus.rd_valid && exp_rd.size() != 0) begin
            check("rd_hold_data", bus.rd_data, exp_rd[0]);
        end
        if (bus.rd_valid) check("no_read_in_hold", {31'b0, bus.mem_read}, 32'd0);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        mem[a] <= d;
    endtask

    task automatic start_xfer(input logic d, input logic [15:0] a, input logic [15:0] n);
        dir = d; base_addr = a; length = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, done}, 32'd1);
    endtask

    task automatic send_word(input logic [15:0] d);
        int n = 0;
        bus.wr_data = d; bus.wr_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (bus.wr_ready !== 1'b1 && n < 20);
        check("wr_accept", {31'b0, bus.wr_ready}, 32'd1);
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int dc0;
        rst_n = 1'b0; start = 1'b0; dir = 1'b0; base_addr = '0; length = '0;
        bus.rd_ready = 1'b0; bus.wr_valid = 1'b0; bus.wr_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {26'b0, busy, done, bus.mem_read, bus.mem_write, bus.rd_valid, bus.wr_ready}, 32'd0);
        check("reset_addr", bus.mem_addr, 32'd0);
        check("reset_rd_data", bus.rd_data, 32'd0);
        preload(16'd10, 16'd5); preload(16'd11, 16'd6); preload(16'd12, 16'd7); preload(16'd13, 16'd8);
        preload(16'hFFFF, 16'h00AA); preload(16'h0000, 16'h00BB);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: streaming read with rd_ready held high
        for (int i = 0; i < 4; i++) begin
            exp_raddr.push_back(16'(10 + i));
            exp_rd.push_back(16'(5 + i));
        end
        bus.rd_ready = 1'b1;
        start_xfer(1'b0, 16'd10, 16'd4);
        check("t1_busy", {31'b0, busy}, 32'd1);
        wait_done("t1_done", 40);
        @(posedge clk); #1;
        check("t1_done_after_hs", done_cyc - last_hs_cyc, 32'd1);
        check("t1_idle", {30'b0, busy, done}, 32'd0);
        check("t1_rd_drained", exp_rd.size(), 32'd0);

        // 2: same read with back-pressure of 3 cycles per word
        for (int i = 0; i < 4; i++) begin
            exp_raddr.push_back(16'(10 + i));
            exp_rd.push_back(16'(5 + i));
        end
        bus.rd_ready = 1'b0;
        start_xfer(1'b0, 16'd10, 16'd4);
        for (int w = 0; w < 4; w++) begin
            n = 0;
            while (bus.rd_valid !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("t2_valid_seen", {31'b0, bus.rd_valid}, 32'd1);
            repeat (3) @(posedge clk);
            #1 bus.rd_ready = 1'b1;
            @(posedge clk); #1;
            bus.rd_ready = 1'b0;
        end
        wait_done("t2_done", 20);
        @(posedge clk); #1;
        check("t2_rd_drained", exp_rd.size(), 32'd0);
        check("t2_raddr_drained", exp_raddr.size(), 32'd0);

        // 3: write two words then read them back
        exp_wr.push_back({16'd14, 16'd23});
        exp_wr.push_back({16'd15, 16'd2});
        start_xfer(1'b1, 16'd14, 16'd2);
        send_word(16'd23);
        send_word(16'd2);
        wait_done("t3_wr_done", 20);
        @(posedge clk); #1;
        check("t3_wr_drained", exp_wr.size(), 32'd0);
        check("t3_mem14", mem[14], 32'd23);
        check("t3_mem15", mem[15], 32'd2);
        exp_raddr.push_back(16'd14); exp_raddr.push_back(16'd15);
        exp_rd.push_back(16'd23);    exp_rd.push_back(16'd2);
        bus.rd_ready = 1'b1;
        start_xfer(1'b0, 16'd14, 16'd2);
        wait_done("t3_rd_done", 20);
        @(posedge clk); #1;
        check("t3_rd_drained", exp_rd.size(), 32'd0);

        // 4: zero length finishes without touching memory
        start_xfer(1'b0, 16'd100, 16'd0);
        @(negedge clk);
        check("t4_done", {31'b0, done}, 32'd1);
        check("t4_no_strobe", {30'b0, bus.mem_read, bus.mem_write}, 32'd0);
        @(posedge clk); #1;
        check("t4_done_pulse", {30'b0, busy, done}, 32'd0);

        // 5: address wraps from FFFF to 0000
        exp_raddr.push_back(16'hFFFF); exp_raddr.push_back(16'h0000);
        exp_rd.push_back(16'h00AA);    exp_rd.push_back(16'h00BB);
        start_xfer(1'b0, 16'hFFFF, 16'd2);
        wait_done("t5_done", 20);
        @(posedge clk); #1;
        check("t5_raddr_drained", exp_raddr.size(), 32'd0);
        check("t5_rd_drained", exp_rd.size(), 32'd0);

        // 6: reset after the first of three writes aborts the block
        exp_wr.push_back({16'd20, 16'd1});
        start_xfer(1'b1, 16'd20, 16'd3);
        send_word(16'd1);
        n = 0;
        while (bus.mem_write !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t6_first_write", {31'b0, bus.mem_write}, 32'd1);
        @(posedge clk); #1;
        bus.wr_data = 16'd2; bus.wr_valid = 1'b1; rst_n = 1'b0;
        @(posedge clk); #1;
        check("t6_reset_outs", {26'b0, busy, done, bus.mem_read, bus.mem_write, bus.rd_valid, bus.wr_ready}, 32'd0);
        check("t6_reset_addr", bus.mem_addr, 32'd0);
        check("t6_reset_wdata", bus.mem_wdata, 32'd0);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1 bus.wr_valid = 1'b0;
        check("t6_wr_drained", exp_wr.size(), 32'd0);
        check("t6_stay_idle", {31'b0, busy}, 32'd0);

        // start pulse during a busy read must not launch a second transfer
        exp_raddr.push_back(16'd10);
        exp_rd.push_back(16'd5);
        dc0 = done_cnt;
        start_xfer(1'b0, 16'd10, 16'd1);
        length = 16'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t6_rd_done", 20);
        repeat (5) @(posedge clk);
        #1;
        check("t6_one_done", done_cnt - dc0, 32'd1);
        check("final_raddr_drained", exp_raddr.size(), 32'd0);
        check("final_rd_drained", exp_rd.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
